// File: rtl/pc_next_datapath.sv
// pc_next_datapath: program-counter register plus the next-PC, destination
// register and writeback-data selection paths of a single-cycle MIPS-style core.
// Optional feature: define PC_JUMP_EN to add the jump / jump_index inputs
// (pseudo-direct jump target with priority over a taken branch).
module pc_next_datapath (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [31:0] imm,
    input  logic        branch_taken,
`ifdef PC_JUMP_EN
    input  logic        jump,
    input  logic [25:0] jump_index,
`endif
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic        regdst,
    input  logic [31:0] alu_result,
    input  logic [31:0] mem_rdata,
    input  logic        memtoreg,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic [31:0] pc_branch,
    output logic [31:0] pc_next,
    output logic [4:0]  reg_a3,
    output logic [31:0] wd3
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    // Next-PC arithmetic and selection; sums wrap modulo 2^32.
    always_comb begin
        // NOTE: every signal written here gets a value on every path first,
        // so no latch can be inferred.
        pc4       = pc_q + 32'd4;
        pc_branch = pc4 + {imm[29:0], 2'b00};
        pc_next   = branch_taken ? pc_branch : pc4;
`ifdef PC_JUMP_EN
        if (jump) begin
            pc_next = {pc4[31:28], jump_index, 2'b00};
        end
`endif
        pc_d = en ? pc_next : pc_q;
    end

    // Destination-register and writeback-data selection.
    always_comb begin
        reg_a3 = regdst ? rd : rt;
        wd3    = memtoreg ? mem_rdata : alu_result;
    end

    // PC register: cleared asynchronously, loads pc_d on each rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: non-blocking assignment keeps every flop sampling the
            // pre-edge values regardless of statement order.
            pc_q <= 32'h0000_0000;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: tb/tb_pc_next_datapath.sv
// Directed self-checking bench for pc_next_datapath. Expected values are pushed
// into a scoreboard queue when stimulus is applied and popped when the matching
// DUT output is sampled.
module tb_pc_next_datapath;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [31:0] imm;
    logic        branch_taken;
`ifdef PC_JUMP_EN
    logic        jump;
    logic [25:0] jump_index;
`endif
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        regdst;
    logic [31:0] alu_result;
    logic [31:0] mem_rdata;
    logic        memtoreg;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] pc_branch;
    logic [31:0] pc_next;
    logic [4:0]  reg_a3;
    logic [31:0] wd3;

    typedef struct {
        string       tag;
        logic [31:0] value;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    pc_next_datapath dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .imm          (imm),
        .branch_taken (branch_taken),
`ifdef PC_JUMP_EN
        .jump         (jump),
        .jump_index   (jump_index),
`endif
        .rt           (rt),
        .rd           (rd),
        .regdst       (regdst),
        .alu_result   (alu_result),
        .mem_rdata    (mem_rdata),
        .memtoreg     (memtoreg),
        .pc           (pc),
        .pc4          (pc4),
        .pc_branch    (pc_branch),
        .pc_next      (pc_next),
        .reg_a3       (reg_a3),
        .wd3          (wd3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_val(input string tag, input logic [31:0] value);
        exp_t e;
        e.tag   = tag;
        e.value = value;
        sb_q.push_back(e);
    endtask

    task automatic check(input logic [31:0] observed);
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%h required=<entry>", observed);
        end else begin
            e = sb_q.pop_front();
            assert (observed === e.value) else begin
                errors++;
                $error("FAIL %s observed=%h required=%h", e.tag, observed, e.value);
            end
        end
    endtask

    // One rising edge, then sample 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n        = 1'b0;
        en           = 1'b0;
        imm          = 32'd0;
        branch_taken = 1'b0;
`ifdef PC_JUMP_EN
        jump         = 1'b0;
        jump_index   = 26'd0;
`endif
        rt           = 5'd0;
        rd           = 5'd0;
        regdst       = 1'b0;
        alu_result   = 32'd0;
        mem_rdata    = 32'd0;
        memtoreg     = 1'b0;
        #2;

        // Reset state and combinational outputs derived from pc=0.
        expect_val("reset_pc", 32'h0);          check(pc);
        expect_val("reset_pc4", 32'h4);         check(pc4);
        expect_val("reset_pc_branch", 32'h4);   check(pc_branch);
        imm = 32'd15;
        #1;
        expect_val("reset_pc_branch_imm15", 32'h40); check(pc_branch);
        expect_val("reset_pc_next_seq", 32'h4);      check(pc_next);

        // Release reset away from the edge and branch to 0x40.
        @(negedge clk);
        rst_n        = 1'b1;
        en           = 1'b1;
        branch_taken = 1'b1;
        step();
        expect_val("branch_to_40", 32'h40); check(pc);
        en           = 1'b0;
        branch_taken = 1'b0;
        imm          = 32'd0;

        // Asynchronous reset mid-run, sampled well before the next edge.
        #1;
        rst_n = 1'b0;
        #1;
        expect_val("async_reset_pc", 32'h0); check(pc);

        // Release and count up sequentially.
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;
        step(); expect_val("seq_pc_4", 32'h4);  check(pc);
        step(); expect_val("seq_pc_8", 32'h8);  check(pc);
        step(); expect_val("seq_pc_c", 32'hC);  check(pc);
        step(); expect_val("seq_pc_10", 32'h10); check(pc);

        // Forward branch from 0x10.
        imm          = 32'd3;
        branch_taken = 1'b1;
        #1;
        expect_val("fwd_pc4", 32'h14);       check(pc4);
        expect_val("fwd_pc_branch", 32'h20); check(pc_branch);
        expect_val("fwd_pc_next", 32'h20);   check(pc_next);
        step();
        expect_val("fwd_pc", 32'h20);        check(pc);

        // Backward branch from 0x20.
        imm = 32'hFFFF_FFFE;
        #1;
        expect_val("bwd_pc_branch", 32'h1C); check(pc_branch);

        // Large backward branch to 0xFFFFFFFC, then wrap of pc4.
        imm = 32'hFFFF_FFF6;
        #1;
        expect_val("bwd_far_target", 32'hFFFF_FFFC); check(pc_next);
        step();
        expect_val("far_pc", 32'hFFFF_FFFC); check(pc);
        branch_taken = 1'b0;
        imm          = 32'd1;
        #1;
        expect_val("wrap_pc4", 32'h0);       check(pc4);
        expect_val("wrap_pc_branch", 32'h4); check(pc_branch);
        expect_val("wrap_pc_next", 32'h0);   check(pc_next);
        step(); expect_val("wrap_pc", 32'h0); check(pc);
        step(); expect_val("post_wrap_4", 32'h4); check(pc);
        step(); expect_val("post_wrap_8", 32'h8); check(pc);

        // Stall at 0x8 for three edges, then resume.
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_val($sformatf("stall_%0d", i), 32'h8); check(pc);
        end
        en = 1'b1;
        step(); expect_val("resume_pc", 32'hC); check(pc);
        en = 1'b0;

        // Immediate bits [31:30] are shifted out of the offset.
        imm = 32'h4000_0001;
        #1;
        expect_val("imm_hi_dropped", 32'h14); check(pc_branch);

        // Destination index and writeback data multiplexers.
        rt         = 5'd5;
        rd         = 5'd17;
        alu_result = 32'h1234;
        mem_rdata  = 32'hBEEF;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        #1;
        expect_val("reg_a3_rt", 32'd5);     check({27'd0, reg_a3});
        expect_val("wd3_alu", 32'h1234);    check(wd3);
        regdst   = 1'b1;
        memtoreg = 1'b1;
        #1;
        expect_val("reg_a3_rd", 32'd17);    check({27'd0, reg_a3});
        expect_val("wd3_mem", 32'hBEEF);    check(wd3);

`ifdef PC_JUMP_EN
        // Jump has priority over a taken branch: reach pc=0x10000000 first.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        rst_n        = 1'b1;
        imm          = 32'h03FF_FFFF;
        branch_taken = 1'b1;
        en           = 1'b1;
        step();
        expect_val("jump_setup_pc", 32'h1000_0000); check(pc);
        en         = 1'b0;
        jump       = 1'b1;
        jump_index = 26'h40;
        #1;
        expect_val("jump_pc_next", 32'h1000_0100); check(pc_next);
        jump = 1'b0;
`endif

        if (sb_q.size() != 0) begin
            errors++;
            $error("FAIL scoreboard_leftover observed=%0d required=0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
